quick_spi_arbiter: RTL

Shares one quick_spi master between NUM_REQ independent client blocks. It runs round-robin arbitration and latches the winner's slave select, operation and outgoing word. It then sequences quick_spi's start_transaction / end_of_transaction handshake and returns incoming data and completion to the granted client. A watchdog aborts transactions whose end_of_transaction never arrives.

---
 rtl/quick_spi_pkg.sv | 23 ++
 rtl/quick_spi_rr_picker.sv | 35 +++
 rtl/quick_spi_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/quick_spi_pkg.sv
// Shared definitions for the quick_spi arbiter slice: FSM encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package quick_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_SLAVE_W        = 2;
    localparam int DEF_OUT_W          = 16;
    localparam int DEF_IN_W           = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Watchdog only has to reach TIMEOUT_CYCLES-1; keep at least one bit when disabled.
    function automatic int wd_width(input int timeout_cycles);
        return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    endfunction

endpackage

// File: rtl/quick_spi_rr_picker.sv
// Round-robin find-first-set over req, searching upward from ptr and wrapping.
// Latency: combinational.
// Backpressure: none; winner is only meaningful while vld is high.
module quick_spi_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               vld
);

    int               pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        vld    = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = PTR_W'(pos);
            if (!vld && req[idx]) begin
                winner[idx] = 1'b1;
                vld         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi master among NUM_REQ clients, with abort watchdog.
// Latency: grant one cycle after arbitration; done one cycle after end_of_transaction (or expiry).
// Backpressure: no grant while spi_end is high; granted fields are frozen until done.
module quick_spi_arbiter
    import quick_spi_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SLAVE_W        = DEF_SLAVE_W,
    parameter int OUT_W          = DEF_OUT_W,
    parameter int IN_W           = DEF_IN_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SLAVE_W-1:0] req_slave,
    input  logic [NUM_REQ-1:0]         req_operation,
    input  logic [NUM_REQ*OUT_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       timeout,
    output logic [IN_W-1:0]            rdata,
    output logic                       spi_enable,
    output logic                       spi_start,
    output logic [SLAVE_W-1:0]         spi_slave,
    output logic                       spi_operation,
    output logic [OUT_W-1:0]           spi_wdata,
    input  logic                       spi_end,
    input  logic [IN_W-1:0]            spi_rdata
);

    localparam int               PTR_W   = $clog2(NUM_REQ);
    localparam int               WD_W    = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t           state, state_nxt;
    logic [NUM_REQ-1:0]   owner;
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [WD_W-1:0]      wd;

    logic [NUM_REQ-1:0]   pick_oh;
    logic                 pick_vld;
    logic [PTR_W-1:0]     pick_idx;
    logic [SLAVE_W-1:0]   sel_slave;
    logic                 sel_op;
    logic [OUT_W-1:0]     sel_wdata;

    logic                 expire;
    logic                 take;
    logic                 finish_ok;
    logic                 finish_to;

    quick_spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_oh),
        .vld    (pick_vld)
    );

    always_comb begin
        pick_idx  = '0;
        sel_slave = '0;
        sel_op    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx  = PTR_W'(i);
                sel_slave = req_slave[i*SLAVE_W +: SLAVE_W];
                sel_op    = req_operation[i];
                sel_wdata = req_wdata[i*OUT_W +: OUT_W];
            end
        end
        ptr_nxt = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pick_vld && !spi_end) state_nxt = ST_BUSY;
            ST_BUSY:    if (spi_end || expire)    state_nxt = ST_RELEASE;
            ST_RELEASE: if (!spi_end)             state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // spi_end on the expiry edge wins: a late but real completion is not an abort.
    always_comb begin
        spi_start = (state == ST_BUSY);
        grant     = spi_start ? owner : '0;
        take      = (state == ST_IDLE) && pick_vld && !spi_end;
        finish_ok = (state == ST_BUSY) && spi_end;
        finish_to = (state == ST_BUSY) && !spi_end && expire;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner         <= '0;
            ptr           <= '0;
            wd            <= '0;
            done          <= '0;
            timeout       <= 1'b0;
            rdata         <= '0;
            spi_enable    <= 1'b0;
            spi_slave     <= '0;
            spi_operation <= 1'b0;
            spi_wdata     <= '0;
        end else begin
            spi_enable <= 1'b1;
            done       <= '0;
            timeout    <= 1'b0;
            if (take) begin
                owner         <= pick_oh;
                ptr           <= ptr_nxt;
                spi_slave     <= sel_slave;
                spi_operation <= sel_op;
                spi_wdata     <= sel_wdata;
                wd            <= '0;
            end else if (state == ST_BUSY) begin
                wd <= wd + WD_W'(1);
            end
            if (finish_ok || finish_to) begin
                done <= owner;
            end
            if (finish_to) begin
                timeout <= 1'b1;
            end
            if (finish_ok) begin
                rdata <= spi_rdata;
            end
        end
    end

endmodule
